ptlut_reader: RTL

PTLUT_READER -- requirements
Module: ptlut_reader

---
 rtl/ptlut_reader_pkg.sv | 35 +++
 rtl/ptlut_slot_sel.sv | 27 ++
 rtl/ptlut_reader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ptlut_reader_pkg.sv
// ptlut_reader_pkg
//   Shared core package for the PT LUT reader: FSM state encoding, default
//   PT LUT data width, PT LUT address width, the spbits constants used by the
//   surrounding track-finder core, and a small helper that picks the lowest
//   set track flag.
//   Optional feature macro used by importers: PTLUT_TIMEOUT_EN.
package ptlut_reader_pkg;

   // PT LUT geometry
   localparam int BW_PT    = 9;
   localparam int PTLUT_AW = 30;

   // spbits constants shared with the rest of the core
   localparam int SPBITS_PHI = 12;
   localparam int SPBITS_TH  = 7;
   localparam int SPBITS_DPH = 13;

   // Reader FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } ptlut_state_t;

   // Index of the lowest set flag; callers only use it with a nonzero vector.
   function automatic logic [1:0] first_set(input logic [2:0] f);
      logic [1:0] idx;
      if (f[0])      idx = 2'd0;
      else if (f[1]) idx = 2'd1;
      else           idx = 2'd2;
      return idx;
   endfunction

endpackage

// File: rtl/ptlut_slot_sel.sv
// ptlut_slot_sel
//   Finds the next set track flag strictly above the current slot.
//   Ports:
//     flags  in   [2:0]  captured per-track valid flags
//     cur    in   [1:0]  slot currently being served
//     nxt    out  [1:0]  lowest set slot above cur (equals cur when none)
//     none   out  1      no set flag above cur
module ptlut_slot_sel (
   input  logic [2:0] flags,
   input  logic [1:0] cur,
   output logic [1:0] nxt,
   output logic       none
);

   always_comb begin
      nxt  = cur;
      none = 1'b1;
      // Scan downward so the lowest qualifying slot is the last one written.
      for (int i = 2; i >= 0; i--) begin
         if ((i > int'(cur)) && flags[i]) begin
            nxt  = 2'(i);
            none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/ptlut_reader.sv
// ptlut_reader
//   Reads PT LUT words for up to three best tracks per batch through a
//   single-outstanding req/gnt + rvalid memory port, in ascending slot order.
//   Handshake: mem_req is held with a stable mem_addr until a cycle where
//   mem_req && mem_gnt; the read then completes on the first mem_rvalid seen
//   while waiting. Only one read is outstanding at a time.
//   Optional feature: PTLUT_TIMEOUT_EN adds a per-read timeout counter and
//   the sticky tmo output.
//   Ports:
//     clk, rst          core clock, async active-high reset
//     ptlut_addr[2:0]   per-track LUT addresses (30 bit)
//     ptlut_addr_val    per-track address valid flags
//     mem_addr/mem_req  read request address / request
//     mem_gnt           request accept strobe
//     mem_rdata/rvalid  read data / data valid
//     pt_out[2:0]       per-track pT results
//     pt_val            result valid flags (done cycle only)
//     pt_done           one-cycle batch-complete strobe
//     ovf               sticky: batch dropped while busy
//     tmo               sticky: a read timed out (PTLUT_TIMEOUT_EN only)
//     dbg_state         current FSM state
module ptlut_reader
   import ptlut_reader_pkg::*;
#(
   parameter int bw_pt   = BW_PT,
   parameter int TIMEOUT = 63
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PTLUT_AW-1:0] ptlut_addr [2:0],
   input  logic [2:0]          ptlut_addr_val,
   output logic [PTLUT_AW-1:0] mem_addr,
   output logic                mem_req,
   input  logic                mem_gnt,
   input  logic [bw_pt-1:0]    mem_rdata,
   input  logic                mem_rvalid,
   output logic [bw_pt-1:0]    pt_out [2:0],
   output logic [2:0]          pt_val,
   output logic                pt_done,
   output logic                ovf,
`ifdef PTLUT_TIMEOUT_EN
   output logic                tmo,
`endif
   output logic [1:0]          dbg_state
);

   ptlut_state_t        state_q, state_d;
   logic [1:0]          slot_q, slot_d;
   logic [2:0]          flags_q, flags_d;
   logic [PTLUT_AW-1:0] addr_q [2:0];
   logic [PTLUT_AW-1:0] addr_d [2:0];
   logic [bw_pt-1:0]    pt_q [2:0];
   logic [bw_pt-1:0]    pt_d [2:0];
   logic [2:0]          pt_val_q, pt_val_d;
   logic                pt_done_q, pt_done_d;
   logic                ovf_q, ovf_d;
   logic                mem_req_q, mem_req_d;
   logic [PTLUT_AW-1:0] mem_addr_q, mem_addr_d;
`ifdef PTLUT_TIMEOUT_EN
   logic [7:0]          cnt_q, cnt_d;
   logic                tmo_q, tmo_d;
`endif

   logic [1:0]          nxt_slot;
   logic                nxt_none;
   logic [1:0]          cap_slot;
   logic                rd_fire;
   logic [bw_pt-1:0]    rd_data;

   ptlut_slot_sel u_slot_sel (
      .flags (flags_q),
      .cur   (slot_q),
      .nxt   (nxt_slot),
      .none  (nxt_none)
   );

   assign cap_slot = first_set(ptlut_addr_val);

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      flags_d    = flags_q;
      addr_d     = addr_q;
      pt_d       = pt_q;
      pt_val_d   = 3'b000;
      pt_done_d  = 1'b0;
      ovf_d      = ovf_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      rd_fire    = 1'b0;
      rd_data    = mem_rdata;
`ifdef PTLUT_TIMEOUT_EN
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            if (|ptlut_addr_val) begin
               // New batch: capture everything and clear stale results.
               addr_d     = ptlut_addr;
               flags_d    = ptlut_addr_val;
               slot_d     = cap_slot;
               for (int i = 0; i < 3; i++) pt_d[i] = '0;
               state_d    = ISSUE;
               mem_req_d  = 1'b1;
               mem_addr_d = ptlut_addr[cap_slot];
            end
         end
         ISSUE: begin
            if (|ptlut_addr_val) ovf_d = 1'b1;
            if (mem_gnt) begin
               state_d   = WAIT;
               mem_req_d = 1'b0;
`ifdef PTLUT_TIMEOUT_EN
               cnt_d     = 8'd0;
`endif
            end
         end
         WAIT: begin
            if (|ptlut_addr_val) ovf_d = 1'b1;
            if (mem_rvalid) begin
               rd_fire = 1'b1;
               rd_data = mem_rdata;
            end
`ifdef PTLUT_TIMEOUT_EN
            else if (cnt_q == 8'(TIMEOUT - 1)) begin
               // Give up on this read and substitute zero data.
               rd_fire = 1'b1;
               rd_data = '0;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
            if (rd_fire) begin
               pt_d[slot_q] = rd_data;
               if (nxt_none) begin
                  state_d   = DONE;
                  pt_done_d = 1'b1;
                  pt_val_d  = flags_q;
               end else begin
                  slot_d     = nxt_slot;
                  state_d    = ISSUE;
                  mem_req_d  = 1'b1;
                  mem_addr_d = addr_q[nxt_slot];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         slot_q     <= 2'd0;
         flags_q    <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            addr_q[i] <= '0;
            pt_q[i]   <= '0;
         end
         pt_val_q   <= 3'b000;
         pt_done_q  <= 1'b0;
         ovf_q      <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
`ifdef PTLUT_TIMEOUT_EN
         cnt_q      <= 8'd0;
         tmo_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         flags_q    <= flags_d;
         addr_q     <= addr_d;
         pt_q       <= pt_d;
         pt_val_q   <= pt_val_d;
         pt_done_q  <= pt_done_d;
         ovf_q      <= ovf_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
`ifdef PTLUT_TIMEOUT_EN
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
`endif
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign pt_out    = pt_q;
   assign pt_val    = pt_val_q;
   assign pt_done   = pt_done_q;
   assign ovf       = ovf_q;
   assign dbg_state = state_q;
`ifdef PTLUT_TIMEOUT_EN
   assign tmo       = tmo_q;
`endif

endmodule
